pf_lanectrl_pause_seq: RTL and testbench

//  Sequencer upstream of the lane-controller pause synchroniser. Takes tap-adjust requests from the
//  RX bit-align FSM and wraps each IOD delay update in a HS_IO_CLK pause window. Order: pause, wait,

---
 rtl/pf_lanectrl_pause_seq_pkg.sv | 19 +
 rtl/pf_lanectrl_pause_seq_timer.sv | 23 ++
 rtl/pf_lanectrl_pause_seq.sv | 145 ++++++++++++++
 tb/tb_pf_lanectrl_pause_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pf_lanectrl_pause_seq_pkg.sv
// pf_lanectrl_pause_seq_pkg: FSM states, burst step spacing and parameter check for the pause sequencer.
package pf_lanectrl_pause_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_UPD,
    S_POST,
    S_SETTLE,
    S_DONE
  } state_e;

  localparam int STEP_SPACE = 2;

  function automatic bit params_ok(input int pre_cycles, input int tap_w, input int max_tap);
    return (pre_cycles >= 3) && (max_tap <= (2 ** tap_w) - 1);
  endfunction

endpackage

// File: rtl/pf_lanectrl_pause_seq_timer.sv
// pf_lanectrl_pause_seq_timer: loadable down-counter with zero and about-to-expire flags.
module pf_lanectrl_pause_seq_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  assign o_zero = (r_cnt == '0);
  assign o_last = (r_cnt == W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= i_load ? i_val : o_zero ? r_cnt : r_cnt - W'(1);
  end

endmodule

// File: rtl/pf_lanectrl_pause_seq.sv
// pf_lanectrl_pause_seq: wraps each IOD tap move/load in a HS_IO_CLK pause window and tracks the tap.
// Optional multi-step bursts inside one pause window are enabled by defining PAUSE_SEQ_BURST_EN.
module pf_lanectrl_pause_seq
  import pf_lanectrl_pause_seq_pkg::*;
#(
  parameter int PRE_CYCLES    = 4,
  parameter int POST_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int TAP_W         = 7,
  parameter int MAX_TAP       = 127,
  parameter int STEP_W        = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_req_load,
  input  logic              i_req_dir,
  input  logic [STEP_W-1:0] i_req_steps,
  output logic              o_ack,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_hs_io_clk_pause,
  output logic              o_delay_move,
  output logic              o_delay_dir,
  output logic              o_delay_load,
  output logic [TAP_W-1:0]  o_tap_cnt
);

  localparam int CW    = (TAP_W > STEP_W ? TAP_W : STEP_W) + 1;
  localparam int TMR_W = $clog2(PRE_CYCLES + POST_CYCLES + SETTLE_CYCLES);

  if (!params_ok(PRE_CYCLES, TAP_W, MAX_TAP)) begin : g_bad_params
    $error("pf_lanectrl_pause_seq: PRE_CYCLES < 3 or MAX_TAP exceeds TAP_W range");
  end

  state_e             r_state, w_state;
  logic               w_tload, w_zero, w_last, w_accept, w_illegal, w_clip, w_pulse_nxt;
  logic [TMR_W-1:0]   w_tval;
  logic [CW-1:0]      w_dist, w_n, r_left;
  logic [TAP_W-1:0]   r_tap;
  logic               r_is_load, r_dir, r_err, r_busy, r_pause, r_ack, r_move, r_load;

  pf_lanectrl_pause_seq_timer #(.W(TMR_W)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_tload),
    .i_val   (w_tval),
    .o_zero  (w_zero),
    .o_last  (w_last)
  );

  assign w_accept  = (r_state == S_IDLE) && i_req;
  assign w_dist    = i_req_dir ? CW'(MAX_TAP) - CW'(r_tap) : CW'(r_tap);
  assign w_illegal = !i_req_load && (w_dist == '0);
`ifdef PAUSE_SEQ_BURST_EN
  logic [CW-1:0] w_nreq;
  assign w_nreq = (i_req_steps == '0) ? CW'(1) : CW'(i_req_steps);
  assign w_clip = !i_req_load && !w_illegal && (w_nreq > w_dist);
  assign w_n    = i_req_load ? CW'(1) : w_clip ? w_dist : w_nreq;
`else
  logic w_unused_steps;
  assign w_unused_steps = ^i_req_steps;
  assign w_clip = 1'b0;
  assign w_n    = CW'(1);
`endif

  // A pulse goes out on UPD entry and then each time the spacing wait is one cycle from expiry.
  assign w_pulse_nxt = (w_state == S_UPD) && ((r_state != S_UPD) || w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_state;
  end

  always_comb begin
    w_state = r_state;
    w_tload = 1'b0;
    w_tval  = '0;
    case (r_state)
      S_IDLE: if (i_req) begin
        w_state = w_illegal ? S_DONE : S_PRE;
        w_tload = !w_illegal;
        w_tval  = TMR_W'(PRE_CYCLES - 1);
      end
      S_PRE: if (w_zero) begin
        w_state = S_UPD;
        w_tload = 1'b1;
      end
      S_UPD: if (w_zero) begin
        w_state = (r_left != '0) ? S_UPD : S_POST;
        w_tload = 1'b1;
        w_tval  = (r_left != '0) ? TMR_W'(STEP_SPACE - 1) : TMR_W'(POST_CYCLES - 1);
      end
      S_POST: if (w_zero) begin
        w_state = S_SETTLE;
        w_tload = 1'b1;
        w_tval  = TMR_W'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: w_state = w_zero ? S_DONE : S_SETTLE;
      S_DONE:   w_state = S_IDLE;
      default:  w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= 1'b0;
      r_pause   <= 1'b0;
      r_ack     <= 1'b0;
      r_move    <= 1'b0;
      r_load    <= 1'b0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_is_load <= 1'b0;
      r_left    <= '0;
      r_tap     <= '0;
    end else begin
      r_busy  <= (w_state != S_IDLE);
      r_pause <= (w_state == S_PRE) || (w_state == S_UPD) || (w_state == S_POST);
      r_ack   <= (w_state == S_DONE);
      r_move  <= w_pulse_nxt && !r_is_load;
      r_load  <= w_pulse_nxt && r_is_load;
      if (w_accept) begin
        r_dir     <= i_req_dir;
        r_is_load <= i_req_load;
        r_err     <= w_illegal || w_clip;
        r_left    <= w_n;
      end
      if (w_pulse_nxt) begin
        r_tap  <= r_is_load ? '0 : r_dir ? r_tap + TAP_W'(1) : r_tap - TAP_W'(1);
        r_left <= r_left - CW'(1);
      end
    end
  end

  assign o_ack             = r_ack;
  assign o_busy            = r_busy;
  assign o_err             = r_err;
  assign o_hs_io_clk_pause = r_pause;
  assign o_delay_move      = r_move;
  assign o_delay_dir       = r_dir;
  assign o_delay_load      = r_load;
  assign o_tap_cnt         = r_tap;

endmodule

// File: tb/tb_pf_lanectrl_pause_seq.sv
// tb_pf_lanectrl_pause_seq: directed checks of pause-window timing, tap limits, load, busy-drop and reset.
module tb_pf_lanectrl_pause_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0, req_load = 1'b0, req_dir = 1'b0;
  logic [3:0] req_steps = '0;
  logic       ack, busy, err, pause, move, ddir, dload;
  logic [6:0] tap;

  int n_cmp = 0, n_bad = 0;
  int p_first, p_last, p_cnt, m_cnt, m_first, m_last, l_cnt, l_k, a_cnt, a_k, b_cnt;
  logic [6:0] tap_k [0:63];

  pf_lanectrl_pause_seq dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_req             (req),
    .i_req_load        (req_load),
    .i_req_dir         (req_dir),
    .i_req_steps       (req_steps),
    .o_ack             (ack),
    .o_busy            (busy),
    .o_err             (err),
    .o_hs_io_clk_pause (pause),
    .o_delay_move      (move),
    .o_delay_dir       (ddir),
    .o_delay_load      (dload),
    .o_tap_cnt         (tap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // REQ is high during cycle t (k=0) and for k < req_cycles; k counts cycles after t.
  task automatic launch(input logic dir, input logic load, input logic [3:0] steps,
                        input int req_cycles, input int ncyc);
    p_first = 0; p_last = 0; p_cnt = 0; m_cnt = 0; m_first = 0; m_last = 0;
    l_cnt = 0; l_k = 0; a_cnt = 0; a_k = 0; b_cnt = 0;
    req_dir = dir; req_load = load; req_steps = steps; req = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      req = (k < req_cycles);
      tap_k[k] = tap;
      if (pause) begin if (p_cnt == 0) p_first = k; p_last = k; p_cnt++; end
      if (move) begin if (m_cnt == 0) m_first = k; m_last = k; m_cnt++; end
      if (dload) begin l_k = k; l_cnt++; end
      if (ack) begin a_k = k; a_cnt++; end
      if (busy) b_cnt++;
    end
    req = 1'b0;
  endtask

  task automatic do_move(input logic dir, input logic [3:0] steps);
    bit seen = 0;
    req_dir = dir; req_load = 1'b0; req_steps = steps; req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (ack) seen = 1;
      tick();
    end
    if (!seen) chk("ramp_ack_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_pause", pause, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_tap", tap, 0);
    rst_n = 1'b1;
    tick();

    // single increment from tap 0
    launch(1'b1, 1'b0, 4'd0, 1, 20);
    chk("t1_pause_first", p_first, 1);
    chk("t1_pause_last", p_last, 9);
    chk("t1_pause_cnt", p_cnt, 9);
    chk("t1_move_cnt", m_cnt, 1);
    chk("t1_move_k", m_first, 5);
    chk("t1_load_cnt", l_cnt, 0);
    chk("t1_tap_before", tap_k[4], 0);
    chk("t1_tap_at_pulse", tap_k[5], 1);
    chk("t1_ack_k", a_k, 18);
    chk("t1_ack_cnt", a_cnt, 1);
    chk("t1_busy_cnt", b_cnt, 18);
    chk("t1_err", err, 0);
    chk("t1_dir", ddir, 1);

    repeat (126) do_move(1'b1, 4'd0);
    chk("ramp_up_tap", tap, 127);

    // increment at the upper limit is rejected
    launch(1'b1, 1'b0, 4'd0, 1, 6);
    chk("t2_pause_cnt", p_cnt, 0);
    chk("t2_move_cnt", m_cnt, 0);
    chk("t2_ack_k", a_k, 1);
    chk("t2_busy_cnt", b_cnt, 1);
    chk("t2_err", err, 1);
    chk("t2_tap", tap, 127);

    repeat (87) do_move(1'b0, 4'd0);
    chk("ramp_down_tap", tap, 40);

    // load from tap 40 with DIR=0
    launch(1'b0, 1'b1, 4'd0, 1, 20);
    chk("t3_load_cnt", l_cnt, 1);
    chk("t3_load_k", l_k, 5);
    chk("t3_move_cnt", m_cnt, 0);
    chk("t3_tap_before", tap_k[4], 40);
    chk("t3_tap_at_pulse", tap_k[5], 0);
    chk("t3_pause_cnt", p_cnt, 9);
    chk("t3_ack_k", a_k, 18);
    chk("t3_err", err, 0);

    // REQ held through BUSY and the DONE cycle
    launch(1'b1, 1'b0, 4'd0, 19, 30);
    chk("t4_ack_cnt", a_cnt, 1);
    chk("t4_ack_k", a_k, 18);
    chk("t4_move_cnt", m_cnt, 1);
    chk("t4_pause_cnt", p_cnt, 9);
    chk("t4_busy_cnt", b_cnt, 18);
    chk("t4_tap", tap, 1);

    // reset mid-window
    req_dir = 1'b1; req_load = 1'b0; req_steps = '0; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    chk("t5_pause_pre", pause, 1);
    chk("t5_tap_pre", tap, 2);
    rst_n = 1'b0;
    #1;
    chk("t5_pause", pause, 0);
    chk("t5_busy", busy, 0);
    chk("t5_tap", tap, 0);
    chk("t5_dir", ddir, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_pause", pause, 0);

    // decrement at tap 0 is rejected
    launch(1'b0, 1'b0, 4'd0, 1, 6);
    chk("tA_pause_cnt", p_cnt, 0);
    chk("tA_move_cnt", m_cnt, 0);
    chk("tA_ack_k", a_k, 1);
    chk("tA_err", err, 1);
    chk("tA_tap", tap, 0);

`ifdef PAUSE_SEQ_BURST_EN
    repeat (8) do_move(1'b1, 4'd15);
    do_move(1'b1, 4'd5);
    chk("t6_ramp_tap", tap, 125);
    launch(1'b1, 1'b0, 4'd5, 1, 24);
    chk("t6_move_cnt", m_cnt, 2);
    chk("t6_move_first", m_first, 5);
    chk("t6_move_last", m_last, 7);
    chk("t6_tap_mid", tap_k[5], 126);
    chk("t6_pause_first", p_first, 1);
    chk("t6_pause_last", p_last, 11);
    chk("t6_pause_cnt", p_cnt, 11);
    chk("t6_ack_k", a_k, 20);
    chk("t6_err", err, 1);
    chk("t6_tap", tap, 127);
`else
    launch(1'b1, 1'b0, 4'd5, 1, 20);
    chk("t6_move_cnt", m_cnt, 1);
    chk("t6_ack_k", a_k, 18);
    chk("t6_err", err, 0);
    chk("t6_tap", tap, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
